// File: rtl/instr_mem_loader.sv
// instr_mem_loader: UART byte stream to instruction RAM loader; hands the RAM to the CPU after a halt word.
// Optional macro LOADER_TIMEOUT_EN discards a partial word after TIMEOUT_CYCLES idle cycles.
module instr_mem_loader #(
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_DEPTH      = 2048,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic [RAM_WIDTH-1:0] i_pc,
  input  logic                 i_cpu_en,
  output logic [RAM_WIDTH-1:0] o_addra,
  output logic [RAM_WIDTH-1:0] o_dina,
  output logic                 o_wea,
  output logic                 o_ena,
  output logic                 o_loading,
  output logic                 o_load_done,
  output logic                 o_error,
  output logic [11:0]          o_word_count
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
  if (RAM_DEPTH < 1 || RAM_DEPTH > 4096 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("instr_mem_loader: unsupported parameters");
  end
  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] word_q, word_d;
  logic [11:0] word_count_q, word_count_d;
  logic [31:0] shifted;
  logic        rx_ok;
`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
`endif
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    shifted      = {asm_q[23:0], i_rx_data};
    rx_ok        = i_rx_done && (state_q == RECV || state_q == WRITE);
`ifdef LOADER_TIMEOUT_EN
    to_d         = '0;
`endif
    if (state_q == IDLE && i_start) state_d = RECV;
    if (rx_ok) begin
      asm_d      = shifted;
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) begin
        word_d  = shifted;
        state_d = WRITE;
      end
    end
    // byte_cnt is 0 in WRITE, so a byte landing here only starts the next word
    if (state_q == WRITE) begin
      word_count_d = word_count_q + 12'd1;
      state_d      = (word_q == 32'hFFFF_FFFF) ? DONE :
                     (word_count_q == 12'(RAM_DEPTH - 1)) ? ERROR : RECV;
    end
`ifdef LOADER_TIMEOUT_EN
    if (state_q == RECV && !i_rx_done && byte_cnt_q != 2'd0) begin
      if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        byte_cnt_d = 2'd0;
        asm_d      = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_q       <= '0;
      word_count_q <= '0;
`ifdef LOADER_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
`ifdef LOADER_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end
  assign o_addra      = (state_q == DONE) ? i_pc : RAM_WIDTH'(word_count_q);
  assign o_dina       = RAM_WIDTH'(word_q);
  assign o_wea        = state_q == WRITE;
  assign o_ena        = (state_q == WRITE) || (state_q == DONE && i_cpu_en);
  assign o_loading    = state_q == RECV || state_q == WRITE;
  assign o_load_done  = state_q == DONE;
  assign o_error      = state_q == ERROR;
  assign o_word_count = word_count_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized checks of the loader against a word-grouping reference model.
module tb_instr_mem_loader;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TO = 10;
  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_rx_done, i_cpu_en;
  logic [7:0]    i_rx_data;
  logic [W-1:0]  i_pc;
  logic [W-1:0]  o_addra, o_dina;
  logic          o_wea, o_ena, o_loading, o_load_done, o_error;
  logic [11:0]   o_word_count;
  int            checks = 0, errors = 0;
  logic [31:0]   wa[$], wd[$], exp_w[$];
  logic          exp_done, exp_err;

  instr_mem_loader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done), .i_pc(i_pc), .i_cpu_en(i_cpu_en), .o_addra(o_addra),
    .o_dina(o_dina), .o_wea(o_wea), .o_ena(o_ena), .o_loading(o_loading),
    .o_load_done(o_load_done), .o_error(o_error), .o_word_count(o_word_count));

  always #5 i_clk = ~i_clk;

  // every RAM write the DUT issues, in order
  always @(negedge i_clk) if (o_wea) begin
    wa.push_back(o_addra);
    wd.push_back(o_dina);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_rst = 1; i_start = 0; i_rx_done = 0; i_rx_data = 0; i_pc = 0; i_cpu_en = 0;
    tick(2);
    i_rst = 0;
    wa.delete(); wd.delete();
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b; i_rx_done = 1; tick(1); i_rx_done = 0;
  endtask

  task automatic start();
    i_start = 1; tick(1); i_start = 0;
  endtask

  // reference: bytes group big-endian into words; stop after a halt word or when RAM is full
  task automatic model(input logic [7:0] b[$]);
    logic [31:0] w;
    exp_w.delete(); exp_done = 0; exp_err = 0;
    for (int i = 0; i + 3 < b.size() && !exp_done && !exp_err; i += 4) begin
      w = {b[i], b[i+1], b[i+2], b[i+3]};
      exp_w.push_back(w);
      if (w == 32'hFFFF_FFFF) exp_done = 1;
      else if (exp_w.size() == D) exp_err = 1;
    end
  endtask

  task automatic test_reset();
    do_reset(); start(); send(8'hAB); send(8'hCD);
    i_rst = 1; tick(1); i_rst = 0;
    checks += 8;
    if (o_addra !== 0)      begin errors++; $display("FAIL rst_addra got %h want 0", o_addra); end
    if (o_dina !== 0)       begin errors++; $display("FAIL rst_dina got %h want 0", o_dina); end
    if (o_wea !== 0)        begin errors++; $display("FAIL rst_wea got %b want 0", o_wea); end
    if (o_ena !== 0)        begin errors++; $display("FAIL rst_ena got %b want 0", o_ena); end
    if (o_loading !== 0)    begin errors++; $display("FAIL rst_loading got %b want 0", o_loading); end
    if (o_load_done !== 0)  begin errors++; $display("FAIL rst_done got %b want 0", o_load_done); end
    if (o_error !== 0)      begin errors++; $display("FAIL rst_error got %b want 0", o_error); end
    if (o_word_count !== 0) begin errors++; $display("FAIL rst_count got %0d want 0", o_word_count); end
  endtask

  task automatic test_basic_load();
    logic [7:0] b[8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_reset(); start();
    foreach (b[i]) begin send(b[i]); tick(1); end
    tick(3);
    checks += 4;
    if (wa.size() !== 2) begin errors++; $display("FAIL basic_writes got %0d want 2", wa.size()); end
    else begin
      checks += 4;
      if (wd[0] !== 32'h20010005) begin errors++; $display("FAIL basic_w0 got %h want 20010005", wd[0]); end
      if (wd[1] !== 32'hFFFFFFFF) begin errors++; $display("FAIL basic_w1 got %h want ffffffff", wd[1]); end
      if (wa[0] !== 0)            begin errors++; $display("FAIL basic_a0 got %0d want 0", wa[0]); end
      if (wa[1] !== 1)            begin errors++; $display("FAIL basic_a1 got %0d want 1", wa[1]); end
    end
    if (o_load_done !== 1)  begin errors++; $display("FAIL basic_done got %b want 1", o_load_done); end
    if (o_word_count !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", o_word_count); end
    if (o_loading !== 0)    begin errors++; $display("FAIL basic_loading got %b want 0", o_loading); end
  endtask

  task automatic test_done_fetch();
    i_pc = 3; i_cpu_en = 1; #1;
    checks += 3;
    if (o_addra !== 3) begin errors++; $display("FAIL done_addra got %0d want 3", o_addra); end
    if (o_ena !== 1)   begin errors++; $display("FAIL done_ena got %b want 1", o_ena); end
    if (o_wea !== 0)   begin errors++; $display("FAIL done_wea got %b want 0", o_wea); end
    i_cpu_en = 0; i_pc = 1; #1;
    checks += 2;
    if (o_ena !== 0)   begin errors++; $display("FAIL done_ena_off got %b want 0", o_ena); end
    if (o_addra !== 1) begin errors++; $display("FAIL done_addra1 got %0d want 1", o_addra); end
    repeat (5) send(8'h55);
    start(); tick(3);
    checks += 3;
    if (wa.size() !== 2)   begin errors++; $display("FAIL done_no_write got %0d want 2", wa.size()); end
    if (o_load_done !== 1) begin errors++; $display("FAIL done_hold got %b want 1", o_load_done); end
    if (o_word_count !== 2) begin errors++; $display("FAIL done_count got %0d want 2", o_word_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_reset(); start();
    foreach (b[i]) send(b[i]);
    checks += 2;
    if (o_wea !== 1)   begin errors++; $display("FAIL b2b_write_cycle got %b want 1", o_wea); end
    if (o_addra !== 0) begin errors++; $display("FAIL b2b_write_addr got %0d want 0", o_addra); end
    send(8'h11); send(8'hAA); send(8'hBB); send(8'hCC);
    tick(3);
    checks += 3;
    if (wa.size() !== 2) begin errors++; $display("FAIL b2b_writes got %0d want 2", wa.size()); end
    else begin
      checks += 3;
      if (wd[0] !== 32'h01020304) begin errors++; $display("FAIL b2b_w0 got %h want 01020304", wd[0]); end
      if (wd[1] !== 32'h11AABBCC) begin errors++; $display("FAIL b2b_w1 got %h want 11aabbcc", wd[1]); end
      if (wa[1] !== 1)            begin errors++; $display("FAIL b2b_a1 got %0d want 1", wa[1]); end
    end
    if (o_word_count !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", o_word_count); end
    if (o_loading !== 1)    begin errors++; $display("FAIL b2b_loading got %b want 1", o_loading); end
  endtask

  task automatic test_overflow();
    do_reset(); start();
    for (int i = 0; i < 16; i++) send(8'(i + 1));
    tick(3);
    for (int i = 0; i < 4; i++) send(8'h77);
    tick(3);
    checks += 5;
    if (wa.size() !== D)    begin errors++; $display("FAIL ovf_writes got %0d want %0d", wa.size(), D); end
    if (o_error !== 1)      begin errors++; $display("FAIL ovf_error got %b want 1", o_error); end
    if (o_ena !== 0)        begin errors++; $display("FAIL ovf_ena got %b want 0", o_ena); end
    if (o_word_count !== D) begin errors++; $display("FAIL ovf_count got %0d want %0d", o_word_count, D); end
    if (o_addra !== D)      begin errors++; $display("FAIL ovf_addra got %0d want %0d", o_addra, D); end
  endtask

  task automatic test_reset_mid_word();
    do_reset(); start(); send(8'hDE); send(8'hAD);
    do_reset(); start();
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    tick(3);
    checks += 2;
    if (wa.size() !== 1) begin errors++; $display("FAIL midrst_writes got %0d want 1", wa.size()); end
    else begin
      checks += 2;
      if (wd[0] !== 32'h12345678) begin errors++; $display("FAIL midrst_w0 got %h want 12345678", wd[0]); end
      if (wa[0] !== 0)            begin errors++; $display("FAIL midrst_a0 got %0d want 0", wa[0]); end
    end
    if (o_word_count !== 1) begin errors++; $display("FAIL midrst_count got %0d want 1", o_word_count); end
  endtask

  task automatic test_timeout();
    logic [31:0] want;
`ifdef LOADER_TIMEOUT_EN
    want = 32'h01020304;
`else
    want = 32'h99010203;
`endif
    do_reset(); start(); send(8'h99);
    tick(TO);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick(3);
    checks += 1;
    if (wa.size() !== 1) begin errors++; $display("FAIL timeout_writes got %0d want 1", wa.size()); end
    else begin
      checks += 1;
      if (wd[0] !== want) begin errors++; $display("FAIL timeout_w0 got %h want %h", wd[0], want); end
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    logic [31:0] w;
    for (int it = 0; it < 25; it++) begin
      b.delete();
      do_reset();
      if ($urandom_range(0, 1)) send(8'($urandom));
      start();
      for (int k = 0, n = $urandom_range(1, 6); k < n; k++) begin
        w = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        for (int j = 3; j >= 0; j--) b.push_back(w[8*j +: 8]);
      end
      for (int k = 0, n = $urandom_range(0, 3); k < n; k++) b.push_back(8'($urandom));
      foreach (b[i]) begin send(b[i]); tick($urandom_range(0, 2)); end
      tick(3);
      model(b);
      checks += 4;
      if (wa.size() !== exp_w.size()) begin
        errors++; $display("FAIL rnd%0d_writes got %0d want %0d", it, wa.size(), exp_w.size());
      end else begin
        foreach (exp_w[i]) begin
          checks += 2;
          if (wd[i] !== exp_w[i]) begin errors++; $display("FAIL rnd%0d_w%0d got %h want %h", it, i, wd[i], exp_w[i]); end
          if (wa[i] !== i)        begin errors++; $display("FAIL rnd%0d_a%0d got %0d want %0d", it, i, wa[i], i); end
        end
      end
      if (o_load_done !== exp_done) begin errors++; $display("FAIL rnd%0d_done got %b want %b", it, o_load_done, exp_done); end
      if (o_error !== exp_err)      begin errors++; $display("FAIL rnd%0d_error got %b want %b", it, o_error, exp_err); end
      if (o_word_count !== 12'(exp_w.size())) begin
        errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, o_word_count, exp_w.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_done_fetch();
    test_back_to_back();
    test_overflow();
    test_reset_mid_word();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, instruction word and RAM address bus width.
REQ-002 SHALL have parameter RAM_DEPTH, default 2048, number of instruction RAM words.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout, used only with LOADER_TIMEOUT_EN.
REQ-004 SHALL have one clock and a synchronous, active-high reset; the ports are listed below with clock and reset first.
REQ-005 i_clk  input  1  clock; all state updates on the rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_start  input  1  one-cycle pulse that starts a program load.
REQ-008 i_rx_data  input  8  received byte from the UART.
REQ-009 i_rx_done  input  1  one-cycle strobe marking i_rx_data valid.
REQ-010 i_pc  input  RAM_WIDTH  CPU fetch address.
REQ-011 i_cpu_en  input  1  CPU fetch enable.
REQ-012 o_addra  output  RAM_WIDTH  instruction RAM address.
REQ-013 o_dina  output  RAM_WIDTH  instruction RAM write data.
REQ-014 o_wea  output  1  instruction RAM write enable.
REQ-015 o_ena  output  1  instruction RAM enable.
REQ-016 o_loading  output  1  high while in RECV or WRITE.
REQ-017 o_load_done  output  1  high in DONE; releases the RAM to the CPU.
REQ-018 o_error  output  1  high in ERROR (overflow).
REQ-019 o_word_count  output  12  number of words written during the current load.

Function
REQ-020 FSM states SHALL be IDLE, RECV, WRITE, DONE and ERROR.
REQ-021 IDLE SHALL go to RECV on i_start; i_start SHALL be ignored in every other state.
REQ-022 In RECV and WRITE, each i_rx_done SHALL shift i_rx_data into a 32-bit assembly register, first byte in bits [31:24] (big-endian), and increment a 2-bit byte counter.
REQ-023 On the 4th byte, the assembled word SHALL be latched to o_dina, the byte counter SHALL wrap to 0, and the next cycle SHALL be WRITE.
REQ-024 WRITE SHALL last exactly one cycle with o_ena=1, o_wea=1 and o_addra=o_word_count, after which o_word_count SHALL increment.
REQ-025 A byte arriving during WRITE SHALL count as byte 0 of the next word and SHALL NOT be lost.
REQ-026 If the written word is 32'hFFFFFFFF (halt), WRITE SHALL go to DONE; otherwise WRITE SHALL go to RECV.
REQ-027 The halt word SHALL be written to RAM and SHALL be counted in o_word_count.
REQ-028 If o_word_count reaches RAM_DEPTH without a halt word, the FSM SHALL enter ERROR, set o_error=1, perform no further writes, and hold there until reset.
REQ-029 In DONE, o_addra SHALL equal i_pc combinationally, o_ena SHALL equal i_cpu_en, and o_wea SHALL be 0.
REQ-030 DONE SHALL hold until reset; rx bytes received in DONE SHALL be ignored.
REQ-031 In IDLE, RECV and ERROR, o_ena and o_wea SHALL be 0 and o_addra SHALL equal o_word_count.
REQ-032 o_wea SHALL never be 1 outside WRITE.

Reset
REQ-033 i_rst SHALL return the FSM to IDLE from any state, including mid-word and mid-WRITE.
REQ-034 i_rst SHALL clear the byte counter, assembly register, o_dina, o_word_count, o_wea, o_ena, o_loading, o_load_done and o_error to 0.
REQ-035 i_rst SHALL NOT modify RAM contents, and a partial word SHALL be discarded.

Configuration
REQ-036 Macro LOADER_TIMEOUT_EN defined: a counter SHALL clear on each i_rx_done in RECV and increment otherwise while in RECV with byte counter nonzero.
REQ-037 With LOADER_TIMEOUT_EN, when that counter reaches TIMEOUT_CYCLES, the partial word SHALL be discarded, the byte counter cleared, and the FSM SHALL remain in RECV.
REQ-038 LOADER_TIMEOUT_EN undefined: no timeout logic SHALL exist, and a partial word SHALL wait indefinitely.

Verification
REQ-039 Reset, i_start, bytes 20,01,00,05 then FF,FF,FF,FF -> RAM[0]=32'h20010005, RAM[1]=32'hFFFFFFFF, o_load_done=1, o_word_count=2.
REQ-040 In DONE, i_pc=3 with i_cpu_en=1 -> o_addra=3, o_ena=1, o_wea=0; any i_rx_done -> no write.
REQ-041 Byte strobe in the WRITE cycle of word 0, then 3 more bytes AA,BB,CC after a lead byte 11 -> RAM[1]=32'h11AABBCC, no byte dropped.
REQ-042 RAM_DEPTH=4, 16 non-halt bytes -> 4 writes, o_error=1, no 5th o_wea pulse.
REQ-043 i_rst after 2 bytes, then i_start and 4 bytes 12,34,56,78 -> RAM[0]=32'h12345678.
REQ-044 With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=10: byte 99, 10 idle cycles, then 01,02,03,04 -> RAM[0]=32'h01020304; without the macro -> RAM[0]=32'h99010203.
